// File: rtl/free_list_if.sv
// Handshake between the rename-stage free list, dispatch (allocation) and retire (free/flush).
interface free_list_if #(
    parameter int unsigned NUM_ALLOC   = 2,
    parameter int unsigned NUM_FREE    = 2,
    parameter int unsigned PHYS_REG_SZ = 64,
    parameter int unsigned ARCH_REG_SZ = 32
);
    localparam int unsigned DEPTH = PHYS_REG_SZ - ARCH_REG_SZ;
    localparam int unsigned TAG_W = $clog2(PHYS_REG_SZ);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [NUM_ALLOC-1:0]            alloc_req;
    logic [NUM_ALLOC-1:0][TAG_W-1:0] alloc_tags;
    logic                            alloc_ok;
    logic [CNT_W-1:0]                free_count;
    logic [NUM_FREE-1:0]             retire_valid;
    logic [NUM_FREE-1:0][TAG_W-1:0]  retire_told;
    logic                            flush;

    modport master (
        output alloc_req, retire_valid, retire_told, flush,
        input  alloc_tags, alloc_ok, free_count
    );

    modport slave (
        input  alloc_req, retire_valid, retire_told, flush,
        output alloc_tags, alloc_ok, free_count
    );
endinterface

// File: rtl/free_list.sv
// Circular free list of physical register tags for R10k-style rename, with
// all-or-nothing multi-port allocation, compacted retirement frees and one-cycle flush recovery.
module free_list #(
    parameter int unsigned NUM_ALLOC   = 2,
    parameter int unsigned NUM_FREE    = 2,
    parameter int unsigned PHYS_REG_SZ = 64,
    parameter int unsigned ARCH_REG_SZ = 32
) (
    input  logic       clock,
    input  logic       reset,
    free_list_if.slave bus
);
    localparam int unsigned DEPTH = PHYS_REG_SZ - ARCH_REG_SZ;
    localparam int unsigned TAG_W = $clog2(PHYS_REG_SZ);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // Pointers wrap at DEPTH, which need not be a power of two; off never exceeds DEPTH.
    function automatic ptr_t ptr_add(ptr_t base, cnt_t off);
        logic [CNT_W:0] sum;
        sum = (CNT_W+1)'(base) + (CNT_W+1)'(off);
        if (sum >= (CNT_W+1)'(DEPTH)) begin
            sum = sum - (CNT_W+1)'(DEPTH);
        end
        return ptr_t'(sum);
    endfunction

    tag_t entries_q [DEPTH];
    tag_t entries_d [DEPTH];
    ptr_t head_q, head_d;
    ptr_t tail_q, tail_d;
    ptr_t retire_head_q, retire_head_d;
    cnt_t spec_count_q, spec_count_d;

    cnt_t alloc_off [NUM_ALLOC];
    cnt_t alloc_cnt;
    cnt_t free_off [NUM_FREE];
    cnt_t free_cnt;
    logic alloc_ok;
    logic alloc_fire;
    logic [CNT_W:0] spec_sum;

    // Prefix popcounts: each requesting/retiring slot gets the next consecutive list index.
    always_comb begin
        alloc_off = '{default: '0};
        alloc_cnt = '0;
        for (int i = 0; i < NUM_ALLOC; i++) begin
            alloc_off[i] = alloc_cnt;
            alloc_cnt    = alloc_cnt + cnt_t'(bus.alloc_req[i]);
        end
    end

    always_comb begin
        free_off = '{default: '0};
        free_cnt = '0;
        for (int j = 0; j < NUM_FREE; j++) begin
            free_off[j] = free_cnt;
            free_cnt    = free_cnt + cnt_t'(bus.retire_valid[j]);
        end
    end

    // Non-requesting slots still present a tag; dispatch ignores them.
    always_comb begin
        bus.alloc_tags = '0;
        for (int i = 0; i < NUM_ALLOC; i++) begin
            bus.alloc_tags[i] = entries_q[ptr_add(head_q, alloc_off[i])];
        end
    end

    assign alloc_ok       = alloc_cnt <= spec_count_q;
    assign bus.alloc_ok   = alloc_ok;
    assign bus.free_count = spec_count_q;

    // Frees are written even in a flush cycle.
    always_comb begin
        entries_d = entries_q;
        for (int j = 0; j < NUM_FREE; j++) begin
            if (bus.retire_valid[j]) begin
                entries_d[ptr_add(tail_q, free_off[j])] = bus.retire_told[j];
            end
        end
    end

    always_comb begin
        alloc_fire    = alloc_ok && !bus.flush;
        tail_d        = ptr_add(tail_q, free_cnt);
        retire_head_d = ptr_add(retire_head_q, free_cnt);
        head_d        = head_q;
        spec_sum      = {1'b0, spec_count_q} + {1'b0, free_cnt}
                        - (alloc_fire ? {1'b0, alloc_cnt} : '0);
        spec_count_d  = spec_sum[CNT_W-1:0];
        if (bus.flush) begin
            // Rewind to committed state, including this cycle's retirements.
            head_d       = retire_head_d;
            spec_count_d = cnt_t'(DEPTH);
        end else if (alloc_fire) begin
            head_d = ptr_add(head_q, alloc_cnt);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q        <= '0;
            tail_q        <= '0;
            retire_head_q <= '0;
            spec_count_q  <= cnt_t'(DEPTH);
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= tag_t'(ARCH_REG_SZ + i);
            end
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            retire_head_q <= retire_head_d;
            spec_count_q  <= spec_count_d;
            entries_q     <= entries_d;
        end
    end

    logic told_zero;
    logic over_free;

    always_comb begin
        told_zero = 1'b0;
        for (int j = 0; j < NUM_FREE; j++) begin
            if (bus.retire_valid[j] && (bus.retire_told[j] == '0)) begin
                told_zero = 1'b1;
            end
        end
    end

    assign over_free = {1'b0, free_cnt} > ((CNT_W+1)'(DEPTH) - {1'b0, spec_count_q});

    a_legal_input: assert property (@(posedge clock) disable iff (reset)
        !(told_zero || over_free));
    a_ptr_sync: assert property (@(posedge clock) disable iff (reset)
        tail_q == retire_head_q);
    a_count_bound: assert property (@(posedge clock) disable iff (reset)
        spec_count_q <= cnt_t'(DEPTH));
endmodule
